// File: rtl/fpm_arb_pkg.sv
// Shared types and constants for the FPM_32 issue arbiter.
package fpm_arb_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned TAG_W       = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INFLIGHT = 2'd1,
        ST_DONE     = 2'd2
    } req_state_e;

endpackage

// File: rtl/fpm_rr_arbiter.sv
// Round-robin picker: first eligible requester after the pointer, wrapping to 0.
module fpm_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_c_o,
    output logic [IDX_W-1:0]   idx_c_o,
    output logic               any_c_o
);

    int unsigned cand;

    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        any_c_o = 1'b0;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_c_o && elig_i[IDX_W'(cand)]) begin
                any_c_o                = 1'b1;
                gnt_c_o[IDX_W'(cand)]  = 1'b1;
                idx_c_o                = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fpm_issue_arbiter.sv
// Shares one pipelined FPM_32 multiplier among NUM_REQ requesters with a tag pipe
// routing results back. Define FPM_ARB_STATS_EN to add stat_ops/stat_busy counters.
module fpm_issue_arbiter
    import fpm_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned DATA_W   = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_x,
    input  logic [NUM_REQ*DATA_W-1:0] req_y,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [NUM_REQ*DATA_W-1:0] rsp_m,
    output logic [DATA_W-1:0]         mul_x,
    output logic [DATA_W-1:0]         mul_y,
    output logic                      mul_vld,
    input  logic [DATA_W-1:0]         mul_m
`ifdef FPM_ARB_STATS_EN
    ,
    output logic [31:0]               stat_ops,
    output logic [31:0]               stat_busy
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TP_D  = PIPE_LAT + 1;

    req_state_e                state_q [NUM_REQ];
    logic [IDX_W-1:0]          ptr_q;
    logic [NUM_REQ-1:0]        rsp_valid_q;
    logic [NUM_REQ*DATA_W-1:0] rsp_m_q;
    logic [DATA_W-1:0]         mul_x_q;
    logic [DATA_W-1:0]         mul_y_q;
    logic                      mul_vld_q;
    logic [TP_D-1:0]           tag_vld_q;
    logic [IDX_W-1:0]          tag_idx_q [TP_D];

    logic [NUM_REQ-1:0]        elig_c;
    logic [NUM_REQ-1:0]        gnt_c;
    logic [IDX_W-1:0]          gnt_idx_c;
    logic                      issue_c;
    logic [DATA_W-1:0]         sel_x_c;
    logic [DATA_W-1:0]         sel_y_c;
    logic                      cap_vld_c;
    logic [IDX_W-1:0]          cap_idx_c;

    // Only IDLE requesters compete; nothing is granted while reset is held.
    always_comb begin
        elig_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            elig_c[i] = req_valid[i] && (state_q[i] == ST_IDLE) && !rst;
        end
    end

    fpm_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .elig_i  (elig_c),
        .ptr_i   (ptr_q),
        .gnt_c_o (gnt_c),
        .idx_c_o (gnt_idx_c),
        .any_c_o (issue_c)
    );

    always_comb begin
        sel_x_c = '0;
        sel_y_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_c[i]) begin
                sel_x_c = req_x[i*DATA_W +: DATA_W];
                sel_y_c = req_y[i*DATA_W +: DATA_W];
            end
        end
    end

    // The last tag stage lines up with the cycle mul_m carries that op's product.
    assign cap_vld_c = tag_vld_q[PIPE_LAT];
    assign cap_idx_c = tag_idx_q[PIPE_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            rsp_valid_q <= '0;
            rsp_m_q     <= '0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            mul_vld_q   <= 1'b0;
            tag_vld_q   <= '0;
            for (int k = 0; k < int'(TP_D); k++) begin
                tag_idx_q[k] <= '0;
            end
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                state_q[i] <= ST_IDLE;
            end
        end else begin
            mul_vld_q    <= issue_c;
            mul_x_q      <= sel_x_c;
            mul_y_q      <= sel_y_c;
            tag_vld_q[0] <= issue_c;
            tag_idx_q[0] <= gnt_idx_c;
            if (issue_c) begin
                ptr_q <= gnt_idx_c;
            end
            for (int k = 1; k < int'(TP_D); k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
            // Capture and response handshakes act on different states, so they never collide.
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (gnt_c[i]) begin
                            state_q[i] <= ST_INFLIGHT;
                        end
                    end
                    ST_INFLIGHT: begin
                        if (cap_vld_c && (cap_idx_c == IDX_W'(i))) begin
                            state_q[i]                   <= ST_DONE;
                            rsp_valid_q[i]               <= 1'b1;
                            rsp_m_q[i*DATA_W +: DATA_W]  <= mul_m;
                        end
                    end
                    ST_DONE: begin
                        if (rsp_ready[i]) begin
                            state_q[i]     <= ST_IDLE;
                            rsp_valid_q[i] <= 1'b0;
                        end
                    end
                    default: begin
                        state_q[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign req_ready = gnt_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_m     = rsp_m_q;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign mul_vld   = mul_vld_q;

`ifdef FPM_ARB_STATS_EN
    logic [31:0] ops_q;
    logic [31:0] busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q  <= '0;
            busy_q <= '0;
        end else begin
            ops_q  <= ops_q + 32'(issue_c);
            busy_q <= busy_q + 32'(mul_vld_q);
        end
    end

    assign stat_ops  = ops_q;
    assign stat_busy = busy_q;
`endif

endmodule

// File: tb/tb_fpm_issue_arbiter.sv
// Randomized and directed bench for fpm_issue_arbiter against a per-requester
// transaction model and a behavioural pipelined multiplier.
module tb_fpm_issue_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned DW  = 32;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_x;
    logic [NR*DW-1:0]  req_y;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [NR*DW-1:0]  rsp_m;
    logic [DW-1:0]     mul_x;
    logic [DW-1:0]     mul_y;
    logic              mul_vld;
    logic [DW-1:0]     mul_m;
`ifdef FPM_ARB_STATS_EN
    logic [31:0]       stat_ops;
    logic [31:0]       stat_busy;
`endif

    fpm_issue_arbiter #(
        .NUM_REQ  (NR),
        .PIPE_LAT (LAT),
        .DATA_W   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_m     (rsp_m),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_vld   (mul_vld),
        .mul_m     (mul_m)
`ifdef FPM_ARB_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_busy (stat_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating single-precision multiply for normal operands.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] man;
        int          e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        if (p[47]) begin
            man = p[46:24];
            e   = e + 1;
        end else begin
            man = p[45:23];
        end
        if (e < 1 || e > 254) return 32'd0;
        return {a[31] ^ b[31], 8'(e), man};
    endfunction

    logic [31:0] mpipe [LAT];
    always_ff @(posedge clk) begin
        mpipe[0] <= fp_mul(mul_x, mul_y);
        for (int k = 1; k < int'(LAT); k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_m = mpipe[LAT-1];

    // Reference model: per-requester status, one pending op each.
    int          m_state [NR];   // 0 free, 1 waiting on multiplier, 2 result held
    logic [31:0] m_rsp   [NR];
    int          p_due   [NR];
    logic [31:0] p_prod  [NR];
    int          m_ptr;
    logic        m_mv;
    logic [31:0] m_mx, m_my;
    logic [31:0] m_ops, m_busy;
    logic [31:0] tx [NR];
    logic [31:0] ty [NR];
    int          cyc;
    int          last_gnt;
    int          n_cmp, n_bad;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_regs();
        logic [NR-1:0]    ev;
        logic [NR*DW-1:0] em;
        for (int i = 0; i < int'(NR); i++) begin
            ev[i]           = (m_state[i] == 2);
            em[i*DW +: DW]  = m_rsp[i];
        end
        chk("mul_vld", 128'(mul_vld), 128'(m_mv));
        chk("mul_x", 128'(mul_x), 128'(m_mx));
        chk("mul_y", 128'(mul_y), 128'(m_my));
        chk("rsp_valid", 128'(rsp_valid), 128'(ev));
        chk("rsp_m", 128'(rsp_m), 128'(em));
`ifdef FPM_ARB_STATS_EN
        chk("stat_ops", 128'(stat_ops), 128'(m_ops));
        chk("stat_busy", 128'(stat_busy), 128'(m_busy));
`endif
    endtask

    // One clock cycle: starts and ends at a falling edge.
    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] rr);
        int c;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < int'(NR); i++) begin
            req_x[i*DW +: DW] = tx[i];
            req_y[i*DW +: DW] = ty[i];
        end
        #1;
        last_gnt = -1;
        for (int k = 1; k <= int'(NR); k++) begin
            c = (m_ptr + k) % int'(NR);
            if (last_gnt < 0 && v[c] && m_state[c] == 0) last_gnt = c;
        end
        chk("req_ready", 128'(req_ready), (last_gnt < 0) ? 128'd0 : (128'd1 << last_gnt));
        @(posedge clk);
        m_busy = m_busy + 32'(m_mv);
        for (int i = 0; i < int'(NR); i++)
            if (m_state[i] == 2 && rr[i]) m_state[i] = 0;
        for (int i = 0; i < int'(NR); i++)
            if (m_state[i] == 1 && p_due[i] == cyc) begin
                m_state[i] = 2;
                m_rsp[i]   = p_prod[i];
            end
        if (last_gnt >= 0) begin
            m_state[last_gnt] = 1;
            p_due[last_gnt]   = cyc + 1 + int'(LAT);
            p_prod[last_gnt]  = fp_mul(tx[last_gnt], ty[last_gnt]);
            m_ptr = last_gnt;
            m_mv  = 1'b1;
            m_mx  = tx[last_gnt];
            m_my  = ty[last_gnt];
            m_ops = m_ops + 32'd1;
        end else begin
            m_mv = 1'b0;
            m_mx = '0;
            m_my = '0;
        end
        cyc++;
        @(negedge clk);
        chk_regs();
    endtask

    // Asserted at a falling edge; registered outputs must clear at once.
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < int'(NR); i++) begin
            m_state[i] = 0;
            m_rsp[i]   = '0;
        end
        m_ptr  = int'(NR) - 1;
        m_mv   = 1'b0;
        m_mx   = '0;
        m_my   = '0;
        m_ops  = '0;
        m_busy = '0;
        #1;
        chk("rst_mul_vld", 128'(mul_vld), 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        @(negedge clk);
        @(negedge clk);
        chk_regs();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
    endfunction

    int g_seq [$];

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1'b1; req_valid = '0; rsp_ready = '0; req_x = '0; req_y = '0;
        for (int i = 0; i < int'(NR); i++) begin tx[i] = '0; ty[i] = '0; end
        @(negedge clk);
        do_reset();

        // Single op latency and value.
        tx[0] = 32'h3F000000; ty[0] = 32'h40000000;
        step(4'b0001, 4'b0000);
        chk("t1_gnt", 128'(last_gnt), 128'd0);
        step(4'b0000, 4'b0000);
        chk("t1_early", 128'(rsp_valid[0]), 128'd0);
        step(4'b0000, 4'b0000);
        chk("t1_early", 128'(rsp_valid[0]), 128'd0);
        step(4'b0000, 4'b0000);
        chk("t1_rise", 128'(rsp_valid[0]), 128'd1);
        chk("t1_prod", 128'(rsp_m[31:0]), 128'h3F800000);
        step(4'b0000, 4'b0001);

        // All four requesters back to back.
        do_reset();
        for (int i = 0; i < int'(NR); i++) begin tx[i] = rnd_fp(); ty[i] = rnd_fp(); end
        for (int k = 0; k < int'(NR); k++) begin
            step(4'b1111, 4'b0000);
            chk("t2_gnt", 128'(last_gnt), 128'(k));
        end
        for (int k = 0; k < 6; k++) step(4'b0000, 4'b0000);
        chk("t2_all_done", 128'(rsp_valid), 128'hF);
        step(4'b0000, 4'b1111);

        // Held result under back-pressure.
        do_reset();
        tx[1] = 32'hBF000000; ty[1] = 32'hBF000000;
        step(4'b0010, 4'b0000);
        for (int k = 0; k < 4; k++) step(4'b0010, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            step(4'b0010, 4'b0000);
            chk("t3_hold", 128'(rsp_m[63:32]), 128'h3E800000);
            chk("t3_noready", 128'(req_ready[1]), 128'd0);
        end
        step(4'b0000, 4'b0010);

        // Handshake and valid in the same cycle: re-issue only afterwards.
        do_reset();
        tx[2] = 32'h40400000; ty[2] = 32'h3FC00000;
        step(4'b0100, 4'b0000);
        for (int k = 0; k < 3; k++) step(4'b0100, 4'b0000);
        chk("t4_prod", 128'(rsp_m[95:64]), 128'h40900000);
        step(4'b0100, 4'b0100);
        chk("t4_no_reissue", 128'(last_gnt), -128'sd1);
        step(4'b0100, 4'b0000);
        chk("t4_reissue", 128'(last_gnt), 128'd2);
        for (int k = 0; k < 4; k++) step(4'b0000, 4'b0100);

        // Reset with an op in flight.
        do_reset();
        tx[0] = rnd_fp(); ty[0] = rnd_fp();
        step(4'b0001, 4'b0000);
        chk("t5_inflight", 128'(mul_vld), 128'd1);
        do_reset();
        for (int k = 0; k < 6; k++) step(4'b0000, 4'b0000);
        chk("t5_no_late", 128'(rsp_valid), 128'd0);

        // Fairness between two persistent requesters.
        do_reset();
        for (int k = 0; k < 24; k++) begin
            step(4'b1001, 4'b1111);
            if (last_gnt >= 0) g_seq.push_back(last_gnt);
        end
        chk("t6_count", 128'(g_seq.size() >= 6), 128'd1);
        for (int k = 0; k < g_seq.size(); k++)
            chk("t6_alt", 128'(g_seq[k]), (k % 2 == 0) ? 128'd0 : 128'd3);
        for (int k = 0; k < 6; k++) step(4'b0000, 4'b1111);

        // Random traffic.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < int'(NR); i++) begin tx[i] = rnd_fp(); ty[i] = rnd_fp(); end
            step(4'($urandom), 4'($urandom));
            if (k == 300) begin
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
